// File: rtl/pipo_arb_pkg.sv
// pipo_arb_pkg: shared state encoding and round-robin pick function for pipo_rr_sched
package pipo_arb_pkg;
  localparam int MAX_REQ = 32;
  localparam int IDX_W = 5;
  typedef enum logic {IDLE, HOLD} state_t;
  typedef struct packed {
    logic found;
    logic [IDX_W-1:0] idx;
  } pick_t;
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req, input int ptr, input int n);
    pick_t p;
    int k;
    p = '0;
    for (int i = MAX_REQ - 1; i >= 0; i--) begin
      k = (ptr + i >= n) ? ptr + i - n : ptr + i;
      if (i < n && req[k]) begin
        p.found = 1'b1;
        p.idx = IDX_W'(k);
      end
    end
    return p;
  endfunction
endpackage

// File: rtl/pipo_rr_pick.sv
// pipo_rr_pick: first set request at or after ptr, wrapping modulo N_REQ
module pipo_rr_pick
  import pipo_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic                     found,
  output logic [$clog2(N_REQ)-1:0] win
);
  pick_t p;
  // rotate by ptr, priority-encode, rotate back
  always_comb begin
    p = rr_pick(MAX_REQ'(req), 32'(ptr), N_REQ);
    found = p.found;
    win = $bits(win)'(p.idx);
  end
endmodule

// File: rtl/pipo_rr_sched.sv
// pipo_rr_sched: round-robin shared PIPO holding register (optional owner lock via PIPO_ARB_LOCK_EN)
module pipo_rr_sched
  import pipo_arb_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int WIDTH       = 4,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
`ifdef PIPO_ARB_LOCK_EN
  input  logic [N_REQ-1:0]         lock_i,
`endif
  input  logic [N_REQ-1:0]         req_i,
  input  logic [N_REQ*WIDTH-1:0]   data_i,
  output logic [N_REQ-1:0]         ack_o,
  output logic [WIDTH-1:0]         po_o,
  output logic                     po_valid_o,
  output logic [$clog2(N_REQ)-1:0] owner_o,
  output logic                     busy_o
);
  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(HOLD_CYCLES + 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] ptr, pick, win, nxt_ptr;
  logic found, arb, lock_hit;
  pipo_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req   (req_i),
    .ptr   (ptr),
    .found (found),
    .win   (pick)
  );
`ifdef PIPO_ARB_LOCK_EN
  assign lock_hit = po_valid_o && req_i[owner_o] && lock_i[owner_o];
`else
  assign lock_hit = 1'b0;
`endif
  assign busy_o = state == HOLD;
  // a locked owner overrides the round-robin pick and freezes the pointer
  always_comb begin
    arb = state == IDLE || cnt == '0;
    win = lock_hit ? owner_o : pick;
    nxt_ptr = lock_hit ? ptr : (pick == IW'(N_REQ - 1) ? '0 : pick + 1'b1);
  end
  // FSM, hold counter, pointer and holding register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      ptr <= '0;
      po_o <= '0;
      po_valid_o <= 1'b0;
      ack_o <= '0;
      owner_o <= '0;
    end else begin
      ack_o <= '0;
      if (!arb) cnt <= cnt - 1'b1;
      else if (found) begin
        state <= HOLD;
        cnt <= CW'(HOLD_CYCLES);
        ptr <= nxt_ptr;
        po_o <= data_i[win*WIDTH +: WIDTH];
        owner_o <= win;
        po_valid_o <= 1'b1;
        ack_o <= N_REQ'(1) << win;
      end else state <= IDLE;
    end
  end
endmodule
